fcu_sprite_port: RTL and testbench
==================================

# fcu_sprite_port

Sprite-side access port of the FCU (sprite controller), directly downstream of the 68000 chip-select decoder. It turns the decoded `sprite_ofs_cs`, `sprite_cs`, `sprite_size_cs` and `frame_done_cs` strobes into indirect, auto-incrementing accesses to sprite RAM and sprite-size RAM. At each vblank start it copies the live RAMs into a display buffer, so the sprite renderer always sees a complete, stable frame.

## Interface
Parameters:
- SPR_AW, 10: sprite RAM word-address width (1024 × 16-bit words).
- SIZE_AW, 6: sprite-size RAM word-address width (64 × 16-bit words).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sprite_ofs_cs  in  1  offset register select, from the chip-select decoder.
- sprite_cs  in  1  sprite RAM data-port select.
- sprite_size_cs  in  1  size RAM data-port select.
- frame_done_cs  in  1  frame-done status select.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_ds_n  in  2  data strobes, active-low; [1] = upper byte, [0] = lower byte.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  registered read data.
- cpu_dtack_n  out  1  bus-cycle acknowledge, active-low.
- vblank  in  1  vertical blank, level.
- disp_spr_addr  in  SPR_AW  renderer sprite-buffer read address.
- disp_spr_data  out  16  sprite-buffer read data.
- disp_size_addr  in  SIZE_AW  renderer size-buffer read address.
- disp_size_data  out  16  size-buffer read data.

## Operation
- Access start: rising edge of (any cs AND any strobe low), registered. Each CPU bus cycle produces exactly one access.
- Offset register `ofs` (SPR_AW bits):
  - Write to sprite_ofs_cs loads `cpu_din[SPR_AW-1:0]`.
  - Read of sprite_ofs_cs returns `ofs` zero-extended.
- sprite_cs:
  - Write stores to live sprite RAM at `ofs`, honouring byte strobes, then increments `ofs`.
  - Read returns live RAM[`ofs`] and does not increment.
- sprite_size_cs:
  - Same behaviour as sprite_cs, but addresses live size RAM[`ofs[SIZE_AW-1:0]`].
  - Write increments the shared `ofs`.
- `ofs` increments modulo 2^SPR_AW: 0x3FF + 1 wraps to 0x000.
- frame_done_cs read returns {15'b0, vblank & ~copy_busy}. Writes are ignored.
- Reads of any other register are undefined and may return 0.
- Copy engine FSM, states IDLE, COPY_SPR, COPY_SIZE, HOLD:
  - IDLE → COPY_SPR on the vblank rising edge; index cleared to 0.
  - COPY_SPR copies one word per cycle, live → buffer, indices 0..2^SPR_AW-1, then goes to COPY_SIZE.
  - COPY_SIZE copies 0..2^SIZE_AW-1 the same way, then goes to HOLD.
  - HOLD → IDLE when vblank is low.
  - copy_busy = state ∈ {COPY_SPR, COPY_SIZE}.
- CPU writes during a copy land in live RAM. A word already copied is not re-copied until the next vblank.
- vblank falling mid-copy does not abort the copy.
- A vblank rising edge while not in IDLE is ignored.
- Reset:
  - `ofs` = 0, FSM = IDLE, cpu_dout = 0, cpu_dtack_n = 1.
  - RAM contents are not cleared.
  - A copy in progress at reset is abandoned.

## Timing
- Access start at cycle N (edge registered): RAM read at N+1, and `cpu_dout` plus `cpu_dtack_n` = 0 at N+2.
- `cpu_dtack_n` stays 0 until all cs/strobes deassert, then returns to 1 on the next cycle.
- RAM write and `ofs` increment commit at N+1. Back-to-back bus cycles see the updated `ofs`.
- Display read latency is 1 cycle: address at cycle K, data at K+1.
- Full copy takes 2^SPR_AW + 2^SIZE_AW = 1088 cycles from the vblank edge to HOLD.
- The CPU uses the live-RAM port and the copy engine uses a second read port, so CPU accesses are never stalled.

## Configuration
- FCU_SPRITE_BUFFER_EN defined: double buffering and the copy FSM are built as described above.
- FCU_SPRITE_BUFFER_EN undefined:
  - No buffer RAMs and no FSM.
  - Display ports read the live RAMs directly through their second port.
  - copy_busy = 0, so frame_done reads return vblank.

## Structure
- Shared package `toaplan1_pkg`:
  - Copy-FSM state enum.
  - Default SPR_AW/SIZE_AW constants.
  - frame-done bit index.
- Sub-module `fcu_dpram`: parameterised true dual-port RAM with byte enables on port A. Instantiated twice (live, buffer) per RAM type, or once per type without FCU_SPRITE_BUFFER_EN.

## Test plan
- Write ofs = 0x3FE, then sprite_cs writes 0x1111, 0x2222, 0x3333 → live[0x3FE] = 0x1111, live[0x3FF] = 0x2222, live[0x000] = 0x3333; `ofs` reads back 0x001.
- ofs = 0x010, then two sprite_cs reads → both return live[0x010], `ofs` stays 0x010. Write with cpu_ds_n = 2'b10 of 0xABCD over 0x0000 → word becomes 0x00CD.
- ofs = 0x045, then sprite_size_cs write 0x00F7 → size[0x05] = 0x00F7, `ofs` = 0x046.
- Fill live RAM, raise vblank → frame_done reads 0 during the copy and 1 from cycle 1088 on; the display port returns the new data. CPU write to index 0 at cycle 500 of the copy does not appear in the buffer.
- Assert reset at cycle 300 of a copy → FSM IDLE, `ofs` = 0, `cpu_dtack_n` = 1. The next vblank edge performs a full copy.
- Build without FCU_SPRITE_BUFFER_EN: a write is visible on the display port immediately, and frame_done follows vblank.

Source files
------------

// File: rtl/toaplan1_pkg.sv
// toaplan1_pkg
//   Shared definitions for the toaplan1 FCU blocks:
//   - default sprite / size RAM address widths
//   - bit position of the frame-done flag in the status word
//   - copy-engine state encoding
//   - CPU access-target decode helper
package toaplan1_pkg;

  localparam int DEF_SPR_AW     = 10;
  localparam int DEF_SIZE_AW    = 6;
  localparam int FRAME_DONE_BIT = 0;

  // Copy engine: live RAM -> display buffer at vblank start.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COPY_SPR  = 2'd1,
    COPY_SIZE = 2'd2,
    HOLD      = 2'd3
  } copy_state_t;

  // Which register a latched CPU access targets.
  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_OFS   = 3'd1,
    SEL_SPR   = 3'd2,
    SEL_SIZE  = 3'd3,
    SEL_FRAME = 3'd4
  } acc_sel_t;

  // The decoder should only ever raise one select at a time; if several
  // are seen, the offset register wins, then sprite, size, frame-done.
  function automatic acc_sel_t decode_sel(input logic ofs_cs,
                                          input logic spr_cs,
                                          input logic size_cs,
                                          input logic frame_cs);
    if (ofs_cs)        return SEL_OFS;
    else if (spr_cs)   return SEL_SPR;
    else if (size_cs)  return SEL_SIZE;
    else if (frame_cs) return SEL_FRAME;
    else               return SEL_NONE;
  endfunction

endpackage

// File: rtl/fcu_dpram.sv
// fcu_dpram
//   True dual-port RAM, 2^AW words of DW bits, registered reads on both
//   ports (read-before-write). Port A has per-byte write enables, port B
//   writes whole words. Storage is split into one array per byte lane so
//   each lane infers a plain block RAM.
// Ports:
//   clk                  clock
//   a_addr/a_we/a_be     port A address, write enable, byte enables
//   a_din/a_dout         port A write data / registered read data
//   b_addr/b_we          port B address, write enable
//   b_din/b_dout         port B write data / registered read data
module fcu_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0]   a_din,
  output logic [DW-1:0]   a_dout,
  input  logic [AW-1:0]   b_addr,
  input  logic            b_we,
  input  logic [DW-1:0]   b_din,
  output logic [DW-1:0]   b_dout
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [0:DEPTH-1];
      logic [7:0] a_q_reg;
      logic [7:0] b_q_reg;

      // On a same-address collision port A takes priority.
      always_ff @(posedge clk) begin
        if (b_we)
          mem[b_addr] <= b_din[gi*8 +: 8];
        if (a_we && a_be[gi])
          mem[a_addr] <= a_din[gi*8 +: 8];
        a_q_reg <= mem[a_addr];
        b_q_reg <= mem[b_addr];
      end

      assign a_dout[gi*8 +: 8] = a_q_reg;
      assign b_dout[gi*8 +: 8] = b_q_reg;
    end
  endgenerate

endmodule

// File: rtl/fcu_sprite_port.sv
// fcu_sprite_port
//   CPU-side sprite access port of the FCU. Decoded chip-select strobes
//   become indirect, auto-incrementing accesses through a shared offset
//   register into live sprite RAM and live sprite-size RAM. With
//   FCU_SPRITE_BUFFER_EN defined, a copy engine snapshots both live RAMs
//   into display buffers at each vblank rising edge; without it the
//   renderer reads the live RAMs directly.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   sprite_ofs_cs       offset register select
//   sprite_cs           sprite RAM data-port select
//   sprite_size_cs      size RAM data-port select
//   frame_done_cs       frame-done status select
//   cpu_rw, cpu_ds_n    1=read / 0=write, active-low byte strobes
//   cpu_din, cpu_dout   CPU write data, registered read data
//   cpu_dtack_n         bus-cycle acknowledge, active-low
//   vblank              vertical blank level
//   disp_spr_addr/data  renderer sprite read port (1-cycle latency)
//   disp_size_addr/data renderer size read port (1-cycle latency)
// Build option: FCU_SPRITE_BUFFER_EN enables double buffering.
module fcu_sprite_port
  import toaplan1_pkg::*;
#(
  parameter int SPR_AW  = DEF_SPR_AW,
  parameter int SIZE_AW = DEF_SIZE_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sprite_ofs_cs,
  input  logic               sprite_cs,
  input  logic               sprite_size_cs,
  input  logic               frame_done_cs,
  input  logic               cpu_rw,
  input  logic [1:0]         cpu_ds_n,
  input  logic [15:0]        cpu_din,
  output logic [15:0]        cpu_dout,
  output logic               cpu_dtack_n,
  input  logic               vblank,
  input  logic [SPR_AW-1:0]  disp_spr_addr,
  output logic [15:0]        disp_spr_data,
  input  logic [SIZE_AW-1:0] disp_size_addr,
  output logic [15:0]        disp_size_data
);

  // ---------------------------------------------------------------
  // CPU access pipeline
  //   N   : start_reg, access latched, RAM write / ofs update issued
  //   N+1 : RAM read data available, ack_pend_reg
  //   N+2 : cpu_dout valid, cpu_dtack_n low
  // ---------------------------------------------------------------
  logic               bus_act;
  logic               act_reg;
  logic               start_reg;
  logic               ack_pend_reg;
  acc_sel_t           sel_reg;
  acc_sel_t           rd_sel_reg;
  logic               rw_reg;
  logic [1:0]         be_reg;
  logic [15:0]        din_reg;
  logic [SPR_AW-1:0]  ofs_reg;
  logic [SPR_AW-1:0]  ofs_next;
  logic [15:0]        cpu_dout_reg;
  logic               dtack_n_reg;
  logic [15:0]        rd_data;
  logic               copy_busy;
  logic               spr_we;
  logic               size_we;
  logic [15:0]        spr_cpu_q;
  logic [15:0]        size_cpu_q;
  logic [SPR_AW-1:0]  spr_b_addr;
  logic [SIZE_AW-1:0] size_b_addr;
  logic [15:0]        spr_b_q;
  logic [15:0]        size_b_q;

  // A bus cycle is any select together with at least one strobe.
  assign bus_act = (sprite_ofs_cs | sprite_cs | sprite_size_cs | frame_done_cs)
                   & ~(&cpu_ds_n);

  assign spr_we  = start_reg & ~rw_reg & (sel_reg == SEL_SPR);
  assign size_we = start_reg & ~rw_reg & (sel_reg == SEL_SIZE);

  always_comb begin
    ofs_next = ofs_reg;
    if (start_reg && !rw_reg) begin
      case (sel_reg)
        SEL_OFS:           ofs_next = din_reg[SPR_AW-1:0];
        SEL_SPR, SEL_SIZE: ofs_next = ofs_reg + 1'b1;  // wraps naturally
        default:           ofs_next = ofs_reg;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel_reg)
      SEL_OFS:   rd_data = 16'(ofs_reg);
      SEL_SPR:   rd_data = spr_cpu_q;
      SEL_SIZE:  rd_data = size_cpu_q;
      SEL_FRAME: rd_data[FRAME_DONE_BIT] = vblank & ~copy_busy;
      default:   rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_reg      <= 1'b0;
      start_reg    <= 1'b0;
      ack_pend_reg <= 1'b0;
      sel_reg      <= SEL_NONE;
      rd_sel_reg   <= SEL_NONE;
      rw_reg       <= 1'b1;
      be_reg       <= 2'b00;
      din_reg      <= '0;
      ofs_reg      <= '0;
      cpu_dout_reg <= '0;
      dtack_n_reg  <= 1'b1;
    end else begin
      act_reg   <= bus_act;
      start_reg <= bus_act & ~act_reg;
      if (bus_act && !act_reg) begin
        sel_reg <= decode_sel(sprite_ofs_cs, sprite_cs, sprite_size_cs, frame_done_cs);
        rw_reg  <= cpu_rw;
        be_reg  <= ~cpu_ds_n;
        din_reg <= cpu_din;
      end
      ofs_reg      <= ofs_next;
      ack_pend_reg <= start_reg;
      rd_sel_reg   <= (start_reg && rw_reg) ? sel_reg : SEL_NONE;
      // Writes leave the last read value on the bus.
      if (ack_pend_reg && rd_sel_reg != SEL_NONE)
        cpu_dout_reg <= rd_data;
      // Ack holds until the CPU drops its selects/strobes.
      if (!bus_act)
        dtack_n_reg <= 1'b1;
      else if (ack_pend_reg)
        dtack_n_reg <= 1'b0;
    end
  end

  assign cpu_dout    = cpu_dout_reg;
  assign cpu_dtack_n = dtack_n_reg;

  // ---------------------------------------------------------------
  // Live RAMs: port A is the CPU, port B is the copy engine (buffered
  // build) or the renderer (unbuffered build).
  // ---------------------------------------------------------------
  fcu_dpram #(.AW(SPR_AW), .DW(16)) u_spr_live (
    .clk    (clk),
    .a_addr (ofs_reg),
    .a_we   (spr_we),
    .a_be   (be_reg),
    .a_din  (din_reg),
    .a_dout (spr_cpu_q),
    .b_addr (spr_b_addr),
    .b_we   (1'b0),
    .b_din  (16'h0000),
    .b_dout (spr_b_q)
  );

  fcu_dpram #(.AW(SIZE_AW), .DW(16)) u_size_live (
    .clk    (clk),
    .a_addr (ofs_reg[SIZE_AW-1:0]),
    .a_we   (size_we),
    .a_be   (be_reg),
    .a_din  (din_reg),
    .a_dout (size_cpu_q),
    .b_addr (size_b_addr),
    .b_we   (1'b0),
    .b_din  (16'h0000),
    .b_dout (size_b_q)
  );

`ifdef FCU_SPRITE_BUFFER_EN
  // ---------------------------------------------------------------
  // Copy engine. Reads live[idx] through port B; the data returns one
  // cycle later, so the buffer write uses a one-stage delayed index.
  // ---------------------------------------------------------------
  localparam logic [SPR_AW-1:0] SPR_LAST  = {SPR_AW{1'b1}};
  localparam logic [SPR_AW-1:0] SIZE_LAST = SPR_AW'((1 << SIZE_AW) - 1);

  copy_state_t       state_reg;
  copy_state_t       state_next;
  logic [SPR_AW-1:0] idx_reg;
  logic [SPR_AW-1:0] idx_next;
  logic              vblank_reg;
  logic              spr_wb_reg;
  logic              size_wb_reg;
  logic [SPR_AW-1:0] wb_idx_reg;
  logic [15:0]       spr_buf_a_q;
  logic [15:0]       size_buf_a_q;

  // Tracked even during reset so a vblank already high when reset is
  // released is not mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    vblank_reg <= vblank;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      spr_wb_reg  <= 1'b0;
      size_wb_reg <= 1'b0;
      wb_idx_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      spr_wb_reg  <= (state_reg == COPY_SPR);
      size_wb_reg <= (state_reg == COPY_SIZE);
      wb_idx_reg  <= idx_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (vblank && !vblank_reg) begin
          state_next = COPY_SPR;
          idx_next   = '0;
        end
      end
      COPY_SPR: begin
        if (idx_reg == SPR_LAST) begin
          state_next = COPY_SIZE;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      COPY_SIZE: begin
        if (idx_reg == SIZE_LAST) begin
          state_next = HOLD;
          idx_next   = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      HOLD: begin
        if (!vblank)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign copy_busy   = (state_reg == COPY_SPR) || (state_reg == COPY_SIZE);
  assign spr_b_addr  = idx_reg;
  assign size_b_addr = idx_reg[SIZE_AW-1:0];

  // Buffers: port A takes the copy writes, port B serves the renderer.
  fcu_dpram #(.AW(SPR_AW), .DW(16)) u_spr_buf (
    .clk    (clk),
    .a_addr (wb_idx_reg),
    .a_we   (spr_wb_reg),
    .a_be   (2'b11),
    .a_din  (spr_b_q),
    .a_dout (spr_buf_a_q),
    .b_addr (disp_spr_addr),
    .b_we   (1'b0),
    .b_din  (16'h0000),
    .b_dout (disp_spr_data)
  );

  fcu_dpram #(.AW(SIZE_AW), .DW(16)) u_size_buf (
    .clk    (clk),
    .a_addr (wb_idx_reg[SIZE_AW-1:0]),
    .a_we   (size_wb_reg),
    .a_be   (2'b11),
    .a_din  (size_b_q),
    .a_dout (size_buf_a_q),
    .b_addr (disp_size_addr),
    .b_we   (1'b0),
    .b_din  (16'h0000),
    .b_dout (disp_size_data)
  );
`else
  // Unbuffered: the renderer reads the live RAMs directly.
  assign copy_busy      = 1'b0;
  assign spr_b_addr     = disp_spr_addr;
  assign size_b_addr    = disp_size_addr;
  assign disp_spr_data  = spr_b_q;
  assign disp_size_data = size_b_q;
`endif

endmodule

// File: tb/tb_fcu_sprite_port.sv
`timescale 1ns/1ps
module tb_fcu_sprite_port;
  localparam int SPR_AW  = 10;
  localparam int SIZE_AW = 6;
  localparam int NSPR    = 1 << SPR_AW;
  localparam int NSIZE   = 1 << SIZE_AW;

  logic               clk = 1'b0;
  logic               reset;
  logic               sprite_ofs_cs, sprite_cs, sprite_size_cs, frame_done_cs;
  logic               cpu_rw;
  logic [1:0]         cpu_ds_n;
  logic [15:0]        cpu_din;
  logic [15:0]        cpu_dout;
  logic               cpu_dtack_n;
  logic               vblank;
  logic [SPR_AW-1:0]  disp_spr_addr;
  logic [15:0]        disp_spr_data;
  logic [SIZE_AW-1:0] disp_size_addr;
  logic [15:0]        disp_size_data;

  always #5 clk = ~clk;

  fcu_sprite_port #(.SPR_AW(SPR_AW), .SIZE_AW(SIZE_AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sprite_ofs_cs  (sprite_ofs_cs),
    .sprite_cs      (sprite_cs),
    .sprite_size_cs (sprite_size_cs),
    .frame_done_cs  (frame_done_cs),
    .cpu_rw         (cpu_rw),
    .cpu_ds_n       (cpu_ds_n),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .cpu_dtack_n    (cpu_dtack_n),
    .vblank         (vblank),
    .disp_spr_addr  (disp_spr_addr),
    .disp_spr_data  (disp_spr_data),
    .disp_size_addr (disp_size_addr),
    .disp_size_data (disp_size_data)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: live RAMs, display buffers, offset, copy-busy flag.
  logic [15:0] m_spr  [NSPR];
  logic [15:0] m_size [NSIZE];
  logic [15:0] b_spr  [NSPR];
  logic [15:0] b_size [NSIZE];
  int          m_ofs = 0;
  bit          m_busy = 1'b0;

  typedef struct {
    bit          is_read;
    logic [15:0] exp;
    string       name;
  } exp_t;
  typedef struct {
    logic [SPR_AW-1:0]  sa;
    logic [SIZE_AW-1:0] za;
    logic [15:0]        es;
    logic [15:0]        ez;
  } disp_t;

  exp_t  cpu_q[$];
  disp_t disp_q[$];
  exp_t  mon_e;
  disp_t mon_d;
  logic  dtack_prev = 1'b1;
  logic  disp_req = 1'b0;
  logic  disp_req_d = 1'b0;

  always @(posedge clk) disp_req_d <= disp_req;

  // Monitor: pops one expectation per acknowledged bus cycle and per
  // display read, independent of the stimulus.
  always @(negedge clk) begin
    if (reset !== 1'b1 && cpu_dtack_n === 1'b0 && dtack_prev === 1'b1) begin
      if (cpu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_dtack: got dtack with no pending access");
      end else begin
        mon_e = cpu_q.pop_front();
        if (mon_e.is_read) begin
          checks++;
          if (cpu_dout !== mon_e.exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", mon_e.name, cpu_dout, mon_e.exp);
          end else
            $display("txn rd %s data=%h", mon_e.name, cpu_dout);
        end else
          $display("txn wr %s", mon_e.name);
      end
    end
    dtack_prev = cpu_dtack_n;
    if (disp_req_d) begin
      if (disp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL disp_unexpected: no pending display read");
      end else begin
        mon_d = disp_q.pop_front();
        checks += 2;
        if (disp_spr_data !== mon_d.es) begin
          errors++;
          $display("FAIL disp_spr[%h]: got=%h expected=%h", mon_d.sa, disp_spr_data, mon_d.es);
        end
        if (disp_size_data !== mon_d.ez) begin
          errors++;
          $display("FAIL disp_size[%h]: got=%h expected=%h", mon_d.za, disp_size_data, mon_d.ez);
        end
        $display("txn disp spr[%h]=%h size[%h]=%h", mon_d.sa, disp_spr_data, mon_d.za, disp_size_data);
      end
    end
  end

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                        input logic [1:0] ds);
    logic [15:0] r;
    r = o;
    if (!ds[1]) r[15:8] = n[15:8];
    if (!ds[0]) r[7:0]  = n[7:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end else
      $display("txn chk %s value=%h", name, got);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  // One CPU bus cycle. sel: 0=ofs 1=sprite 2=size 3=frame_done.
  task automatic bus(input int sel, input bit rw, input logic [1:0] ds,
                     input logic [15:0] din, input string name);
    exp_t e;
    int   n;
    e.is_read = rw;
    e.name    = name;
    e.exp     = 16'h0000;
    if (rw) begin
      case (sel)
        0:       e.exp = 16'(m_ofs);
        1:       e.exp = m_spr[m_ofs];
        2:       e.exp = m_size[m_ofs % NSIZE];
        default: e.exp = {15'b0, vblank & ~m_busy};
      endcase
    end else begin
      case (sel)
        0: m_ofs = int'(din[SPR_AW-1:0]);
        1: begin m_spr[m_ofs] = merge(m_spr[m_ofs], din, ds); m_ofs = (m_ofs + 1) % NSPR; end
        2: begin
          m_size[m_ofs % NSIZE] = merge(m_size[m_ofs % NSIZE], din, ds);
          m_ofs = (m_ofs + 1) % NSPR;
        end
        default: ;
      endcase
    end
    cpu_q.push_back(e);
    @(posedge clk); #1;
    sprite_ofs_cs  = (sel == 0);
    sprite_cs      = (sel == 1);
    sprite_size_cs = (sel == 2);
    frame_done_cs  = (sel == 3);
    cpu_rw = rw; cpu_ds_n = ds; cpu_din = din;
    n = 0;
    while (cpu_dtack_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s_dtack_timeout: got dtack_n=%b expected 0 within 20 cycles", name, cpu_dtack_n);
      if (cpu_q.size() > 0) void'(cpu_q.pop_back());
    end
    @(posedge clk); #1;
    sprite_ofs_cs = 0; sprite_cs = 0; sprite_size_cs = 0; frame_done_cs = 0;
    cpu_ds_n = 2'b11; cpu_rw = 1'b1;
    n = 0;
    while (cpu_dtack_n !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s_dtack_release: got dtack_n=%b expected 1", name, cpu_dtack_n);
    end
  endtask

  task automatic disp_chk(input logic [SPR_AW-1:0] sa, input logic [SIZE_AW-1:0] za);
    disp_t d;
    d.sa = sa; d.za = za;
`ifdef FCU_SPRITE_BUFFER_EN
    d.es = b_spr[int'(sa)]; d.ez = b_size[int'(za)];
`else
    d.es = m_spr[int'(sa)]; d.ez = m_size[int'(za)];
`endif
    disp_q.push_back(d);
    @(posedge clk); #1;
    disp_spr_addr = sa; disp_size_addr = za; disp_req = 1'b1;
    @(posedge clk); #1;
    disp_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic snapshot();
    for (int i = 0; i < NSPR; i++)  b_spr[i]  = m_spr[i];
    for (int i = 0; i < NSIZE; i++) b_size[i] = m_size[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_ofs = 0; m_busy = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sel;
    bit          rw;
    logic [1:0]  ds;
    bit          buf_valid;
    int          t0;
    string       nm [4];
    nm[0] = "ofs"; nm[1] = "spr"; nm[2] = "size"; nm[3] = "frame_done";
    reset = 1'b1;
    sprite_ofs_cs = 0; sprite_cs = 0; sprite_size_cs = 0; frame_done_cs = 0;
    cpu_rw = 1'b1; cpu_ds_n = 2'b11; cpu_din = '0; vblank = 1'b0;
    disp_spr_addr = '0; disp_size_addr = '0;
`ifdef FCU_SPRITE_BUFFER_EN
    buf_valid = 1'b0;
`else
    buf_valid = 1'b1;
`endif
    do_reset();
    @(negedge clk);
    chk("reset_dout", cpu_dout, 16'h0000);
    chk("reset_dtack_n", {15'b0, cpu_dtack_n}, 16'h0001);
    bus(0, 1, 2'b00, 16'h0, "reset_ofs");

    // Fill every live word so later reads have known contents.
    bus(0, 0, 2'b00, 16'h0000, "ofs_wr");
    for (int i = 0; i < NSPR; i++)  bus(1, 0, 2'b00, 16'($urandom), "spr_fill");
    for (int i = 0; i < NSIZE; i++) bus(2, 0, 2'b00, 16'($urandom), "size_fill");
    bus(0, 1, 2'b00, 16'h0, "ofs_after_fill");

    // Auto-increment across the wrap.
    bus(0, 0, 2'b00, 16'h03FE, "ofs_wr");
    bus(1, 0, 2'b00, 16'h1111, "spr_wr");
    bus(1, 0, 2'b00, 16'h2222, "spr_wr");
    bus(1, 0, 2'b00, 16'h3333, "spr_wr");
    bus(0, 1, 2'b00, 16'h0, "ofs_wrapped");
    bus(0, 0, 2'b00, 16'hFBFE, "ofs_wr_upper_ignored");
    bus(1, 1, 2'b00, 16'h0, "spr_3fe");
    bus(0, 0, 2'b00, 16'h03FF, "ofs_wr");
    bus(1, 1, 2'b00, 16'h0, "spr_3ff");
    bus(0, 0, 2'b00, 16'h0000, "ofs_wr");
    bus(1, 1, 2'b00, 16'h0, "spr_000");

    // Reads do not increment; lower-byte-only write.
    bus(0, 0, 2'b00, 16'h0010, "ofs_wr");
    bus(1, 1, 2'b01, 16'h0, "spr_010_rd1");
    bus(1, 1, 2'b10, 16'h0, "spr_010_rd2");
    bus(0, 1, 2'b00, 16'h0, "ofs_still_010");
    bus(1, 0, 2'b00, 16'h0000, "spr_clear");
    bus(0, 0, 2'b00, 16'h0010, "ofs_wr");
    bus(1, 0, 2'b10, 16'hABCD, "spr_lower_byte");
    bus(0, 0, 2'b00, 16'h0010, "ofs_wr");
    bus(1, 1, 2'b00, 16'h0, "spr_010_00cd");
    bus(0, 0, 2'b00, 16'h0010, "ofs_wr");
    bus(1, 0, 2'b01, 16'h5A00, "spr_upper_byte");
    bus(0, 0, 2'b00, 16'h0010, "ofs_wr");
    bus(1, 1, 2'b00, 16'h0, "spr_010_5acd");

    // Size RAM uses the low offset bits and shares the increment.
    bus(0, 0, 2'b00, 16'h0045, "ofs_wr");
    bus(2, 0, 2'b00, 16'h00F7, "size_wr");
    bus(0, 1, 2'b00, 16'h0, "ofs_046");
    bus(0, 0, 2'b00, 16'h0045, "ofs_wr");
    bus(2, 1, 2'b00, 16'h0, "size_05");

`ifndef FCU_SPRITE_BUFFER_EN
    // Unbuffered: display sees live data at once, frame_done follows vblank.
    disp_chk(10'h3FE, 6'h05);
    disp_chk(10'h3FF, 6'h00);
    disp_chk(10'h000, 6'h3F);
    bus(0, 0, 2'b00, 16'h0123, "ofs_wr");
    bus(1, 0, 2'b00, 16'hBEEF, "spr_wr");
    disp_chk(10'h123, 6'h23);
    vblank = 1'b1;
    bus(3, 1, 2'b00, 16'h0, "frame_done_vb1");
    vblank = 1'b0;
    bus(3, 1, 2'b00, 16'h0, "frame_done_vb0");
`else
    // First copy: busy during, done after; a CPU write mid-copy stays live only.
    @(posedge clk); #1;
    vblank = 1'b1; t0 = cyc; snapshot(); m_busy = 1'b1;
    wait_until(t0 + 100);
    bus(3, 1, 2'b00, 16'h0, "frame_done_busy");
    wait_until(t0 + 500);
    bus(0, 0, 2'b00, 16'h0000, "ofs_wr");
    bus(1, 0, 2'b00, 16'hC0DE ^ m_spr[0], "spr0_mid_copy");
    wait_until(t0 + 1200);
    m_busy = 1'b0; buf_valid = 1'b1;
    bus(3, 1, 2'b00, 16'h0, "frame_done_after_copy");
    disp_chk(10'h000, 6'h00);
    disp_chk(10'h3FF, 6'h3F);
    disp_chk(10'h3FE, 6'h05);
    bus(0, 0, 2'b00, 16'h0000, "ofs_wr");
    bus(1, 1, 2'b00, 16'h0, "spr0_live_new");

    // Reset at cycle 300 of a copy abandons it; the next edge copies fully.
    vblank = 1'b0;
    repeat (4) @(posedge clk); #1;
    vblank = 1'b1; t0 = cyc; m_busy = 1'b1;
    bus(0, 0, 2'b00, 16'h0155, "ofs_wr");
    wait_until(t0 + 300);
    do_reset();
    @(negedge clk);
    chk("reset_mid_copy_dtack_n", {15'b0, cpu_dtack_n}, 16'h0001);
    bus(0, 1, 2'b00, 16'h0, "reset_mid_copy_ofs");
    bus(3, 1, 2'b00, 16'h0, "frame_done_idle_after_reset");
    for (int i = 0; i < 8; i++) begin
      bus(0, 0, 2'b00, 16'($urandom_range(0, NSPR - 1)), "ofs_wr");
      bus(1, 0, 2'b00, 16'($urandom), "spr_wr");
      bus(2, 0, 2'b00, 16'($urandom), "size_wr");
    end
    vblank = 1'b0;
    repeat (3) @(posedge clk); #1;
    vblank = 1'b1; t0 = cyc; snapshot(); m_busy = 1'b1;
    wait_until(t0 + 1200);
    m_busy = 1'b0;
    bus(3, 1, 2'b00, 16'h0, "frame_done_after_recopy");
    disp_chk(10'h000, 6'h00);
    disp_chk(10'h12C, 6'h2C);
    disp_chk(10'h3FF, 6'h3F);
    vblank = 1'b0;
    repeat (4) @(posedge clk); #1;
`endif

    // Randomized mix of accesses against the model.
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 3);
      rw  = 1'($urandom_range(0, 1));
      ds  = 2'($urandom_range(0, 2));
      bus(sel, rw, ds, 16'($urandom), nm[sel]);
      if (buf_valid && $urandom_range(0, 3) == 0)
        disp_chk(SPR_AW'($urandom), SIZE_AW'($urandom));
    end

`ifndef FCU_SPRITE_BUFFER_EN
    // Reset with a non-zero offset.
    bus(0, 0, 2'b00, 16'h0155, "ofs_wr");
    do_reset();
    @(negedge clk);
    chk("reset2_dtack_n", {15'b0, cpu_dtack_n}, 16'h0001);
    bus(0, 1, 2'b00, 16'h0, "reset2_ofs");
`endif

    repeat (4) @(posedge clk);
    if (cpu_q.size() != 0 || disp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_expectations: got %0d/%0d left expected 0",
               cpu_q.size(), disp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
